// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory, NOP-fills the rest,
// then releases the core after a guard delay. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int                 INST_W   = 16,
  parameter int                 ADDR_W   = 8,
  parameter logic [INST_W-1:0]  NOP_WORD = 16'h0000,
  parameter int                 HOLD_CYC = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [INST_W-1:0] In_data,
  input  logic              In_last,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [INST_W-1:0] Mem_wdata,
  output logic              Core_hold,
  output logic              Busy,
  output logic              Done,
  output logic              Error
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [INST_W-1:0] Checksum
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_A = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [7:0] HOLD_END = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_RELEASE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     addr_q, addr_d;
  logic [7:0]          hold_q, hold_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [INST_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                core_hold_q, core_hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                hs;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [INST_W-1:0]   csum_q, csum_d;
`endif

  assign In_ready  = (state_q == S_LOAD);
  assign hs        = In_valid & In_ready;
  assign Mem_we    = mem_we_q;
  assign Mem_addr  = mem_addr_q;
  assign Mem_wdata = mem_wdata_q;
  assign Core_hold = core_hold_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Error     = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign Checksum  = csum_q;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    core_hold_d = core_hold_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d     = S_LOAD;
          addr_d      = '0;
          hold_d      = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          core_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d      = '0;
`endif
        end
      end
      S_LOAD: begin
        if (hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q[ADDR_W-1:0];
          mem_wdata_d = In_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d      = csum_q + In_data;
`endif
          if (addr_q == LAST_A) begin
            if (In_last) begin
              state_d = S_RELEASE;
              hold_d  = '0;
            end else begin
              // overflow: keep the core held
              state_d = S_IDLE;
              error_d = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            addr_d = addr_q + 1'b1;
            if (In_last) begin
              state_d = S_FILL;
            end
          end
        end
      end
      S_FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q[ADDR_W-1:0];
        mem_wdata_d = NOP_WORD;
        if (addr_q == LAST_A) begin
          state_d = S_RELEASE;
          hold_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (hold_q == HOLD_END) begin
          state_d     = S_DONE;
          core_hold_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      hold_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_hold_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_hold_q <= core_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: randomized streams vs. a
// high-level model of the expected memory image and release timing.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int DEPTH    = 256;
  localparam int HOLD_CYC = 2;
  localparam logic [15:0] NOP = 16'h0000;

  typedef struct {
    int          addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic        In_valid;
  logic        In_ready;
  logic [15:0] In_data;
  logic        In_last;
  logic        Mem_we;
  logic [7:0]  Mem_addr;
  logic [15:0] Mem_wdata;
  logic        Core_hold;
  logic        Busy;
  logic        Done;
  logic        Error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0] Checksum;
`endif

  imem_loader dut (
    .Clk(Clk),
    .Rst(Rst),
    .Start(Start),
    .In_valid(In_valid),
    .In_ready(In_ready),
    .In_data(In_data),
    .In_last(In_last),
    .Mem_we(Mem_we),
    .Mem_addr(Mem_addr),
    .Mem_wdata(Mem_wdata),
    .Core_hold(Core_hold),
    .Busy(Busy),
    .Done(Done),
    .Error(Error)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .Checksum(Checksum)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc;
  int last_hs;
  logic [15:0] csum;
  logic [15:0] fixed_q[$];
  wr_t sb[$];
  wr_t e;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // monitor: every write must match the next expected write, on its cycle
  always @(negedge Clk) begin
    if (Rst === 1'b1 && Mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0d data %0h, none expected",
                 Mem_addr, Mem_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(Mem_addr), e.addr);
        chk("wr_data", 32'(Mem_wdata), 32'(e.data));
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_core_hold"}, 32'(Core_hold), 1);
    chk({tag, "_mem_we"}, 32'(Mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(Mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(Mem_wdata), 0);
    chk({tag, "_in_ready"}, 32'(In_ready), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_done"}, 32'(Done), 0);
    chk({tag, "_error"}, 32'(Error), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk({tag, "_checksum"}, 32'(Checksum), 0);
`endif
  endtask

  // mode 0: valid always, 1: valid toggles, 2: random gaps
  task automatic do_load(input int n, input int last_idx, input int mode,
                         input bit start_mid);
    int budget;
    bit tog;
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("start_busy", 32'(Busy), 1);
    chk("start_hold", 32'(Core_hold), 1);
    chk("start_done", 32'(Done), 0);
    chk("start_error", 32'(Error), 0);
    chk("start_ready", 32'(In_ready), 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("start_checksum", 32'(Checksum), 0);
`endif
    acc = 0;
    last_hs = -1;
    csum = '0;
    tog = 1'b1;
    budget = 0;
    while (acc < n) begin
      if (In_ready !== 1'b1) break;
      case (mode)
        0: In_valid = 1'b1;
        1: begin In_valid = tog; tog = !tog; end
        default: In_valid = ($urandom_range(0, 3) != 0);
      endcase
      In_data = (fixed_q.size() > acc) ? fixed_q[acc] : 16'($urandom);
      In_last = (acc == last_idx);
      Start = start_mid && (acc == 1);
      #1;
      if (In_valid && In_ready) begin
        sb.push_back('{acc, In_data, cyc + 1});
        if (In_last) begin
          for (int a = acc + 1; a < DEPTH; a++)
            sb.push_back('{a, NOP, cyc + 1 + (a - acc)});
        end
        csum = csum + In_data;
        last_hs = cyc;
        acc++;
      end
      @(negedge Clk);
      budget++;
      if (budget > 4 * n + 20) begin
        chk("load_budget", 32'(budget), 32'(4 * n + 20));
        break;
      end
    end
    In_valid = 1'b0;
    In_last = 1'b0;
    Start = 1'b0;
  endtask

  task automatic wait_release(input int last_idx);
    int t;
    int exp_rel;
    exp_rel = last_hs + 1 + (DEPTH - 1 - last_idx) + HOLD_CYC;
    t = 0;
    while (Core_hold !== 1'b0 && t < 600) begin
      @(negedge Clk);
      t++;
    end
    chk("release_seen", 32'(Core_hold), 0);
    chk("release_cycle", cyc, exp_rel);
    chk("done", 32'(Done), 1);
    chk("busy", 32'(Busy), 0);
    chk("error", 32'(Error), 0);
    chk("sb_empty", sb.size(), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("checksum", 32'(Checksum), 32'(csum));
`endif
  endtask

  initial begin
    int t;
    int n;
    Rst = 1'b0;
    Start = 1'b0;
    In_valid = 1'b0;
    In_data = '0;
    In_last = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_reset("por");
    Rst = 1'b1;
    @(negedge Clk);

    do_load(11, 10, 0, 1'b0);
    chk("fact_accepted", acc, 11);
    wait_release(10);

    do_load(4, 3, 1, 1'b0);
    chk("bp_accepted", acc, 4);
    wait_release(3);

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 40);
      do_load(n, n - 1, 2, 1'b0);
      chk("rand_accepted", acc, n);
      wait_release(n - 1);
    end

    do_load(256, 255, 0, 1'b0);
    chk("full_accepted", acc, 256);
    wait_release(255);

    do_load(257, -1, 0, 1'b0);
    chk("ovf_accepted", acc, 256);
    chk("ovf_error", 32'(Error), 1);
    chk("ovf_ready", 32'(In_ready), 0);
    In_valid = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("ovf_ready_hold", 32'(In_ready), 0);
    end
    In_valid = 1'b0;
    chk("ovf_core_hold", 32'(Core_hold), 1);
    chk("ovf_done", 32'(Done), 0);
    chk("ovf_busy", 32'(Busy), 0);
    chk("ovf_error_sticky", 32'(Error), 1);
    chk("ovf_sb_empty", sb.size(), 0);

    do_load(5, 4, 2, 1'b0);
    t = 0;
    while (!(Mem_we === 1'b1 && Mem_addr == 8'd100) && t < 400) begin
      @(negedge Clk);
      t++;
    end
    chk("fill100_reached", 32'(t < 400), 1);
    #2;
    Rst = 1'b0;
    #1;
    chk_reset("midfill");
    sb.delete();
    repeat (2) @(negedge Clk);
    Rst = 1'b1;

    do_load(3, 2, 0, 1'b1);
    chk("restart_accepted", acc, 3);
    wait_release(2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    fixed_q = '{16'h1000, 16'h2001, 16'hF0FF};
    do_load(3, 2, 0, 1'b0);
    wait_release(2);
    chk("csum_fixed", 32'(Checksum), 32'h2100);
    fixed_q.delete();
    do_load(1, 0, 0, 1'b0);
    wait_release(0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Parametrised instruction-memory loader for the pipelined micro.
- Accepts a stream of instruction words over a valid/ready handshake and writes them through the instruction memory write port from address 0.
- Pads every remaining address with a NOP word.
- Holds the core in reset throughout, then releases it after a programmable guard delay, replacing hierarchical memory pokes in benches and boards.

Parameters:
- INST_W, 16, instruction word width in bits.
- ADDR_W, 8, instruction memory address width; depth is 2**ADDR_W (derived localparam DEPTH).
- NOP_WORD, 16'h0000, fill pattern; must be INST_W bits and match the team's NOP encoding.
- HOLD_CYC, 2, cycles Core_hold stays high after the final memory write; must be 1..255.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
- In_valid  in  1  stream word present.
- In_ready  out  1  loader accepts a word this cycle.
- In_data  in  INST_W  instruction word.
- In_last  in  1  marks the final program word; qualified by In_valid.
- Mem_we  out  1  instruction memory write enable.
- Mem_addr  out  ADDR_W  write address.
- Mem_wdata  out  INST_W  write data.
- Core_hold  out  1  high keeps the micro in reset.
- Busy  out  1  load in progress.
- Done  out  1  load complete; core running.
- Error  out  1  sticky overflow flag.

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE, Core_hold=1, Mem_we=0, Mem_addr=0, Mem_wdata=0, In_ready=0, Busy=0, Done=0, Error=0, internal address and hold counters=0.
- States: IDLE, LOAD, FILL, RELEASE, DONE.
- IDLE/DONE + Start:
  - Go to LOAD; address counter=0; Busy=1; Done=0; Error=0; Core_hold=1.
  - Start in LOAD, FILL or RELEASE is ignored.
- LOAD:
  - In_ready=1 combinationally while in LOAD.
  - A handshake (In_valid & In_ready) registers Mem_we=1, Mem_addr=counter, Mem_wdata=In_data on the next edge; Mem_we is therefore 1 cycle after acceptance.
  - The counter increments per accepted word.
  - No handshake gives Mem_we=0 next cycle. Gaps in In_valid are legal.
- LOAD exit:
  - Accepted word with In_last=1 at counter<DEPTH-1: go to FILL.
  - Accepted word with In_last=1 at counter=DEPTH-1: go to RELEASE, with no fill.
  - Accepted word at counter=DEPTH-1 with In_last=0 (overflow): the word is written; Error=1; go to IDLE with Busy=0 and Core_hold=1. Core stays held until a new successful load.
- FILL:
  - In_ready=0.
  - One write per cycle of NOP_WORD to addresses last+1 .. DEPTH-1.
  - After writing DEPTH-1, go to RELEASE.
  - The address counter must not wrap past DEPTH-1.
- RELEASE:
  - Mem_we=0.
  - Hold counter counts HOLD_CYC cycles after the last write, then Core_hold=0, Done=1, Busy=0, and the state goes to DONE.
- DONE: Core_hold=0 until the next Start, which re-asserts Core_hold=1 on the following edge.
- Width rules: the address counter is ADDR_W bits plus 1 overflow bit; Mem_addr is its low ADDR_W bits.
- Reset mid-operation: immediate return to reset values. Partially written memory is not restored; Core_hold=1 guarantees the core does not run it.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output Checksum (INST_W bits): modulo-2**INST_W sum of all accepted stream words, excluding fill words.
  - Cleared to 0 on reset and on accepted Start; updated on the edge after each handshake.
  - Stable from FILL entry onward.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Factorial load, 11 words, In_valid continuously high, last on word 10:
  - Writes to addresses 0..10 with the stream data on consecutive cycles.
  - Then 245 NOP_WORD writes to addresses 11..255.
  - Core_hold falls 2 cycles after the addr-255 write; Done=1, Error=0.
- Backpressure: 4 words with In_valid toggling 1,0,1,0,...:
  - Exactly 4 writes, to addresses 0..3, each 1 cycle after its handshake.
  - No write in gap cycles; fill covers 4..255.
- Full program, 256 words with In_last on word 255: no FILL writes; RELEASE entered directly; Done after HOLD_CYC cycles.
- Overflow, 257 words with no In_last:
  - 256 writes; Error=1 after the 256th handshake; In_ready=0 afterwards.
  - Core_hold stays 1; Done=0.
- Robustness:
  - Rst pulsed low during FILL at address 100: all outputs return to reset values immediately.
  - A new Start plus a 3-word load completes normally.
  - Start pulsed mid-LOAD has no effect.
- IMEM_LOADER_CHECKSUM_EN defined, words 16'h1000, 16'h2001, 16'hF0FF: Checksum=16'h2100 at Done; re-Start clears it to 0.
